mulu_m7q7_seq: RTL

Sequencing controller for the m7q7 unsigned multiplier. It consumes the two half-cycle input lanes produced by the dual-edge input capture stage (negedge lane and posedge lane) and assembles a start command plus two operands from them. It then runs an iterative shift-add multiply over WIDTH cycles and presents the 2·WIDTH-bit product on an 8-bit output bus, one byte at a time. It sits between the edge-capture front end and the tile output pins.

---
 rtl/mulu_m7q7_seq.sv | 91 +++++++++
 1 files changed

// File: rtl/mulu_m7q7_seq.sv
// mulu_m7q7_seq: sequencing controller for the m7q7 unsigned multiplier.
// Assembles start/operands from the two edge-capture lanes, runs a WIDTH-cycle
// shift-add multiply and presents the product one byte at a time.
module mulu_m7q7_seq #(
  parameter int WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_pos,
  input  logic [7:0] in_neg,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_p;
  logic             r_start_q;

  logic             w_start;
  logic [7:0]       w_b8;
  logic [PW-1:0]    w_addend;
  logic [15:0]      w_p16;

  // Rising edge of the start bit; a held start never re-triggers.
  assign w_start  = in_pos[7] & ~r_start_q;
  // B widened to 8 bits so the 3-bit counter indexes it without width games.
  assign w_b8     = 8'(r_b);
  assign w_addend = PW'(r_a) << r_cnt;
  // Zero-extended product; the upper byte reads 0 for bits beyond 2*WIDTH.
  assign w_p16    = 16'(r_p);

  // Control FSM plus the shift-add datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_p       <= '0;
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= in_pos[7];
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE accepts a new start directly; P is held otherwise.
          if (w_start) begin
            r_a     <= in_pos[WIDTH-1:0];
            r_b     <= in_neg[WIDTH-1:0];
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          // Starts arriving here are dropped on purpose.
          if (w_b8[r_cnt]) r_p <= r_p + w_addend;
          if (r_cnt == 3'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy = (r_state == S_MUL);
    done = (r_state == S_DONE);
  end

  // Byte select follows in_neg[7] with no added latency.
  always_comb begin
    out = in_neg[7] ? w_p16[15:8] : w_p16[7:0];
  end

endmodule
